// File: rtl/btn_scan_pkg.sv
// btn_scan_pkg: shared types and width helpers for the button scan controller.
//   idx_w(n)   : index width for n items (minimum 1 bit)
//   div_w(d)   : sample-divider counter width for a divide ratio d (minimum 1 bit)
//   btn_evt_t  : queued event payload {id, rel}; id is sized for up to 256 buttons
//                and trimmed to the real index width at the top level.
package btn_scan_pkg;

    localparam int EVT_ID_MAX_W = 8;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int div_w(input int d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

    typedef struct packed {
        logic [EVT_ID_MAX_W-1:0] id;
        logic                    rel;
    } btn_evt_t;

endpackage

// File: rtl/btn_evt_fifo.sv
// btn_evt_fifo: small synchronous event queue with the head entry presented
// combinationally from the storage registers (no write-to-read bypass).
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push, wdata: enqueue request and payload
//   pop        : dequeue the head entry (ignored while empty)
//   head       : current head entry, forced to zero while empty
//   full, empty: occupancy flags
//   drop       : push refused because the queue is full and nothing is popped
module btn_evt_fifo
    import btn_scan_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  btn_evt_t wdata,
    input  logic     pop,
    output btn_evt_t head,
    output logic     full,
    output logic     empty,
    output logic     drop
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    btn_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && full && !rd_en;
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: round-robin debouncer for NBTN buttons sharing one sample
// divider and one debounce datapath, feeding a valid/ready event queue.
//   clk, rst   : clock, synchronous active-high reset
//   btn_raw    : asynchronous raw button levels
//   evt_valid  : queue head holds an event
//   evt_ready  : consumer accepts the head event
//   evt_id     : button index of the head event
//   evt_rel    : 1 = release event, 0 = press event
//   btn_level  : debounced levels
//   ovf        : sticky, an event was dropped on a full queue
//   ovf_clr    : clears ovf (a simultaneous drop keeps it set)
// Build option: define BTN_SCAN_RELEASE_EN to also queue release events;
// otherwise only presses are queued and evt_rel stays 0.
module btn_scan_ctrl
    import btn_scan_pkg::*;
#(
    parameter  int NBTN       = 4,
    parameter  int DIV        = 50_000,
    parameter  int N          = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDW        = idx_w(NBTN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDW-1:0]  evt_id,
    output logic            evt_rel,
    output logic [NBTN-1:0] btn_level,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam int               DIV_W    = div_w(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDW-1:0]   IDX_LAST = IDW'(NBTN - 1);

    logic [NBTN-1:0]  sync_p0;
    logic [NBTN-1:0]  sync_p1;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [IDW-1:0]   idx;
    logic [N-1:0]     hist [NBTN];
    logic [NBTN-1:0]  level_q;
    logic [N-1:0]     next_hist;
    logic             cur_level;
    logic             next_level;
    logic             push;
    btn_evt_t         push_evt;
    btn_evt_t         head_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             pop;
    logic             ovf_q;
    logic [EVT_ID_MAX_W-1:0] head_id_unused;

    // Stage p0/p1: two-flop synchronizer on every raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Sample-rate divider and round-robin scan pointer.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDW'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Shared debounce datapath for the button under the scan pointer.
    always_comb begin
        next_hist  = {hist[idx][N-2:0], sync_p1[idx]};
        cur_level  = level_q[idx];
        next_level = cur_level;
        if (&next_hist)       next_level = 1'b1;
        else if (~|next_hist) next_level = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) hist[i] <= '0;
            level_q <= '0;
        end else if (tick) begin
            hist[idx]    <= next_hist;
            level_q[idx] <= next_level;
        end
    end

    // Event generation: at most one per tick, for the scanned button only.
    always_comb begin
        push_evt    = '0;
        push_evt.id = EVT_ID_MAX_W'(idx);
`ifdef BTN_SCAN_RELEASE_EN
        push         = tick && (next_level != cur_level);
        // A change away from 1 is a release.
        push_evt.rel = cur_level;
`else
        push         = tick && next_level && !cur_level;
        push_evt.rel = 1'b0;
`endif
    end

    assign pop = evt_valid && evt_ready;

    btn_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_evt),
        .pop   (pop),
        .head  (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst)            ovf_q <= 1'b0;
        else if (fifo_drop) ovf_q <= 1'b1;
        else if (ovf_clr)   ovf_q <= 1'b0;
    end

    // Upper id bits beyond the real index width carry nothing.
    assign head_id_unused = head_evt.id;

    assign evt_valid = !fifo_empty;
    assign evt_id    = head_evt.id[IDW-1:0];
    assign evt_rel   = head_evt.rel;
    assign btn_level = level_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
`timescale 1ns/1ps
module tb_btn_scan_ctrl;

    localparam int NBTN  = 4;
    localparam int DIV   = 4;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic [NBTN-1:0] btn_raw   = '0;
    logic            evt_ready = 1'b0;
    logic            ovf_clr   = 1'b0;
    logic            evt_valid;
    logic [IDW-1:0]  evt_id;
    logic            evt_rel;
    logic [NBTN-1:0] btn_level;
    logic            ovf;

    always #5 clk = ~clk;

    btn_scan_ctrl #(
        .NBTN       (NBTN),
        .DIV        (DIV),
        .N          (N),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_rel   (evt_rel),
        .btn_level (btn_level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Time is counted in clock edges since reset release; edge k is a sample
    // edge when k mod DIV == DIV-1, and samples button (k/DIV) mod NBTN.
    // Debounce is tracked as "length of the current run of equal samples".
    typedef struct {
        int id;
        int rel;
    } mevt_t;

    int              kc = 0;
    bit              chk_en = 0;
    logic [NBTN-1:0] m_s0, m_s1, m_lvl;
    int              run_len [NBTN];
    bit              run_val [NBTN];
    mevt_t           mq [$];
    bit              m_ovf;

    always @(posedge clk) begin : model
        int    b;
        bit    do_pop, do_push, smp;
        mevt_t ne;
        if (rst) begin
            kc    = 0;
            m_s0  = '0;
            m_s1  = '0;
            m_lvl = '0;
            for (int i = 0; i < NBTN; i++) begin
                run_len[i] = N;
                run_val[i] = 1'b0;
            end
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && evt_ready;
            do_push = 1'b0;
            if (kc % DIV == DIV - 1) begin
                b   = (kc / DIV) % NBTN;
                smp = m_s1[b];
                if (smp == run_val[b]) begin
                    if (run_len[b] < N) run_len[b]++;
                end else begin
                    run_val[b] = smp;
                    run_len[b] = 1;
                end
                if (run_len[b] >= N && run_val[b] != m_lvl[b]) begin
                    m_lvl[b] = run_val[b];
                    ne.id    = b;
                    ne.rel   = run_val[b] ? 0 : 1;
`ifdef BTN_SCAN_RELEASE_EN
                    do_push = 1'b1;
`else
                    do_push = run_val[b];
`endif
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(ne);
                else m_ovf = 1'b1;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
            end
            if (do_push && mq.size() <= DEPTH && !m_ovf && ovf_clr) m_ovf = 1'b0;
            m_s1 = m_s0;
            m_s0 = btn_raw;
            kc++;
        end
        chk_en = 1'b1;
    end

    // ---------------- per-cycle comparison ----------------
    mevt_t pops [$];
    int    first_vk = -1;

    always @(negedge clk) begin
        mevt_t pe;
        if (chk_en) begin
            chk("evt_valid", evt_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("evt_id", evt_id, mq[0].id);
                chk("evt_rel", evt_rel, mq[0].rel);
            end
            chk("btn_level", btn_level, m_lvl);
            chk("ovf", ovf, m_ovf);
            if (evt_valid && first_vk < 0) first_vk = kc;
            if (evt_valid && evt_ready) begin
                pe.id  = evt_id;
                pe.rel = evt_rel;
                pops.push_back(pe);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_k(input int k);
        int guard = 0;
        while (kc < k && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (kc < k) chk("wait_timeout", kc, k);
    endtask

    task automatic do_reset(input int cycles, input logic [NBTN-1:0] raw);
        rst     = 1'b1;
        btn_raw = raw;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            chk("rst_valid", evt_valid, 0);
            chk("rst_id", evt_id, 0);
            chk("rst_rel", evt_rel, 0);
            chk("rst_level", btn_level, 0);
            chk("rst_ovf", ovf, 0);
        end
        rst      = 1'b0;
        first_vk = -1;
        pops.delete();
    endtask

    task automatic chk_pop(input string name, input int i, input int id, input int rel);
        if (pops.size() <= i) begin
            chk({name, "_missing"}, pops.size(), i + 1);
        end else begin
            chk({name, "_id"}, pops[i].id, id);
            chk({name, "_rel"}, pops[i].rel, rel);
        end
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int e_np;
        int rel_np;

        // Buttons held through reset: one press each after release, in id order.
        evt_ready = 1'b1;
        do_reset(3, 4'hF);
        wait_k(80);
        chk("held_count", pops.size(), 4);
        for (int i = 0; i < 4; i++) chk_pop("held", i, i, 0);
        chk("held_first_valid", first_vk, 52);

        // Clean press of button 2: 4th sample is edge 59, valid from the next cycle.
        do_reset(2, 4'h4);
        wait_k(150);
        chk("clean_first_valid", first_vk, 60);
        chk("clean_count", pops.size(), 1);
        chk_pop("clean", 0, 2, 0);
        chk("clean_level", btn_level, 4'b0100);

        // Bounce on button 1 between its samples, then hold.
        do_reset(2, 4'h0);
        for (int j = 0; j < 7; j++) begin
            wait_k(16 * j + 1);
            btn_raw[1] = (j == 1 || j >= 3);
        end
        wait_k(100);
        chk("bounce_quiet", pops.size(), 0);
        wait_k(140);
        chk("bounce_count", pops.size(), 1);
        chk_pop("bounce", 0, 1, 0);
        chk("bounce_level", btn_level, 4'b0010);

        // Overflow: queue four presses, further edges are lost.
        evt_ready = 1'b0;
        do_reset(2, 4'hF);
        wait_k(70);
        btn_raw = 4'h0;
        wait_k(150);
        btn_raw = 4'hF;
        wait_k(240);
        chk("ovf_set", ovf, 1);
        chk("ovf_valid", evt_valid, 1);
        pops.delete();
        evt_ready = 1'b1;
        wait_k(250);
        chk("ovf_drain_count", pops.size(), 4);
        for (int i = 0; i < 4; i++) chk_pop("ovf_drain", i, i, 0);
        chk("ovf_empty", evt_valid, 0);
        chk("ovf_still", ovf, 1);
        ovf_clr = 1'b1;
        wait_k(251);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Full queue, push and pop on the same edge.
`ifdef BTN_SCAN_RELEASE_EN
        e_np   = 115;
        rel_np = 1;
`else
        e_np   = 179;
        rel_np = 0;
`endif
        evt_ready = 1'b0;
        do_reset(2, 4'hF);
        wait_k(64);
        btn_raw[0] = 1'b0;
`ifndef BTN_SCAN_RELEASE_EN
        wait_k(120);
        btn_raw[0] = 1'b1;
`endif
        wait_k(e_np);
        evt_ready = 1'b1;
        wait_k(e_np + 1);
        evt_ready = 1'b0;
        chk("fpp_ovf", ovf, 0);
        chk("fpp_valid", evt_valid, 1);
        pops.delete();
        evt_ready = 1'b1;
        wait_k(e_np + 10);
        chk("fpp_count", pops.size(), 4);
        chk_pop("fpp0", 0, 1, 0);
        chk_pop("fpp1", 1, 2, 0);
        chk_pop("fpp2", 2, 3, 0);
        chk_pop("fpp3", 3, 0, rel_np);

        // Reset with three events queued.
        evt_ready = 1'b0;
        do_reset(2, 4'hF);
        wait_k(60);
        chk("mid_valid_before", evt_valid, 1);
        rst     = 1'b1;
        btn_raw = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_valid_after", evt_valid, 0);
        pops.delete();
        evt_ready = 1'b1;
        wait_k(200);
        chk("mid_no_events", pops.size(), 0);

        // Randomized traffic against the model.
        do_reset(2, 4'h0);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            for (int b = 0; b < NBTN; b++)
                if ($urandom_range(0, 79) == 0) btn_raw[b] = ~btn_raw[b];
            evt_ready = (c % 1000 < 500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            ovf_clr   = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
        end
        rst       = 1'b0;
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
